// File: rtl/slice_pkg.sv
// slice_pkg: state encoding and beat-count helpers shared by the slice serializer and the receive-side converter
package slice_pkg;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    function automatic int beats(input int length, input int slice_size);
        return length / slice_size;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/slice_stream_serializer_lane_mux.sv
// slice_lane_mux: picks one beat's slice out of a lane word field; SLICE_SER_MSB_FIRST_EN reverses the beat order
module slice_lane_mux #(
`ifdef SLICE_SER_MSB_FIRST_EN
    parameter int BEATS           = 8,
`endif
    parameter int MAX_WORD_LENGTH = 32,
    parameter int Slice_Size      = 4,
    parameter int CW              = 3
) (
    input  logic [MAX_WORD_LENGTH-1:0] field,
    input  logic [CW-1:0]              beat,
    output logic [Slice_Size-1:0]      slice
);

    logic [CW-1:0] sel;

`ifdef SLICE_SER_MSB_FIRST_EN
    assign sel = CW'(BEATS - 1) - beat;
`else
    assign sel = beat;
`endif

    assign slice = field[sel * Slice_Size +: Slice_Size];

endmodule

// File: rtl/slice_stream_serializer.sv
// slice_stream_serializer: double-buffered word-to-slice serializer; SLICE_SER_MSB_FIRST_EN selects MSB-first slice order
module slice_stream_serializer
    import slice_pkg::*;
#(
    parameter int SIZE            = 1,
    parameter int PE              = 2,
    parameter int MAX_WORD_LENGTH = 32,
    parameter int LENGTH          = 32,
    parameter int Slice_Size      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 word_valid,
    output logic                                 word_ready,
    input  logic [SIZE*PE*MAX_WORD_LENGTH-1:0]   word_data,
    output logic                                 slice_valid,
    input  logic                                 slice_ready,
    output logic [SIZE*PE*Slice_Size-1:0]        slice_data,
    output logic                                 slice_first,
    output logic                                 slice_last,
    output logic                                 busy
);

    localparam int LANES = SIZE * PE;
    localparam int BEATS = beats(LENGTH, Slice_Size);
    localparam int CW    = cnt_w(BEATS);
    localparam int WW    = LANES * MAX_WORD_LENGTH;

    state_t          state;
    logic [CW-1:0]   beat;
    logic [WW-1:0]   active;
    logic [WW-1:0]   pending;
    logic [LANES*Slice_Size-1:0] lane_slice;
    logic            accept;
    logic            consume;
    logic            last_beat;

    assign word_ready  = (state != TWO) && !flush;
    assign accept      = word_valid && word_ready;
    assign slice_valid = (state != EMPTY);
    assign busy        = (state != EMPTY);
    assign consume     = slice_valid && slice_ready;
    assign last_beat   = (beat == CW'(BEATS - 1));
    assign slice_first = slice_valid && (beat == '0);
    assign slice_last  = slice_valid && last_beat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        slice_lane_mux #(
`ifdef SLICE_SER_MSB_FIRST_EN
            .BEATS           (BEATS),
`endif
            .MAX_WORD_LENGTH (MAX_WORD_LENGTH),
            .Slice_Size      (Slice_Size),
            .CW              (CW)
        ) u_mux (
            .field (active[i*MAX_WORD_LENGTH +: MAX_WORD_LENGTH]),
            .beat  (beat),
            .slice (lane_slice[i*Slice_Size +: Slice_Size])
        );
    end

    // Hold the output at zero whenever no beat is being presented
    always_comb begin
        slice_data = slice_valid ? lane_slice : '0;
    end

    // Buffer occupancy FSM with beat counter; flush overrides every other event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= EMPTY;
            beat    <= '0;
            active  <= '0;
            pending <= '0;
        end else if (flush) begin
            state <= EMPTY;
            beat  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        active <= word_data;
                        beat   <= '0;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (consume && last_beat) begin
                        beat <= '0;
                        if (accept) active <= word_data;
                        else        state  <= EMPTY;
                    end else begin
                        if (consume) beat <= beat + CW'(1);
                        if (accept) begin
                            pending <= word_data;
                            state   <= TWO;
                        end
                    end
                end
                TWO: begin
                    if (consume && last_beat) begin
                        active <= pending;
                        beat   <= '0;
                        state  <= ONE;
                    end else if (consume) begin
                        beat <= beat + CW'(1);
                    end
                end
                default: begin
                    state <= EMPTY;
                    beat  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slice_stream_serializer.sv
// tb_slice_stream_serializer: directed self-checking bench for slice_stream_serializer
module tb_slice_stream_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [63:0] word_data = '0;
    logic        slice_valid;
    logic        slice_ready = 1'b0;
    logic [7:0]  slice_data;
    logic        slice_first;
    logic        slice_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] WORD_A = {32'h12345678, 32'hDEADBEEF};
    localparam logic [63:0] WORD_B = {32'hFEDCBA98, 32'h76543210};

    logic [7:0] exp_a [8];
    logic [7:0] exp_b [8];

    slice_stream_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .slice_valid (slice_valid),
        .slice_ready (slice_ready),
        .slice_data  (slice_data),
        .slice_first (slice_first),
        .slice_last  (slice_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (slice_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", slice_valid); end
        checks++;
        if (word_ready !== 1'b1) begin errors++; $display("FAIL reset_word_ready got %b exp 1", word_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++;
        if (slice_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", slice_data); end
        checks++;
        if ({slice_first, slice_last} !== 2'b00) begin errors++; $display("FAIL reset_first_last got %b exp 00", {slice_first, slice_last}); end
    endtask

    task automatic test_single_word();
        word_data = WORD_A; word_valid = 1'b1; slice_ready = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (slice_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d got %b exp 1", b, slice_valid); end
            checks++;
            if (slice_data !== exp_a[b]) begin errors++; $display("FAIL single_data beat %0d got %h exp %h", b, slice_data, exp_a[b]); end
            checks++;
            if (slice_first !== (b == 0)) begin errors++; $display("FAIL single_first beat %0d got %b exp %b", b, slice_first, b == 0); end
            checks++;
            if (slice_last !== (b == 7)) begin errors++; $display("FAIL single_last beat %0d got %b exp %b", b, slice_last, b == 7); end
            @(negedge clk);
        end
        checks++;
        if (slice_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid got %b exp 0", slice_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_end_busy got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        word_data = WORD_A; word_valid = 1'b1; slice_ready = 1'b1;
        @(negedge clk);
        word_data = WORD_B;
        checks++;
        if (word_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_one got %b exp 1", word_ready); end
        checks++;
        if (slice_data !== exp_a[0]) begin errors++; $display("FAIL b2b_data beat 0 got %h exp %h", slice_data, exp_a[0]); end
        @(negedge clk);
        word_valid = 1'b0;
        for (int k = 1; k < 16; k++) begin
            e = (k < 8) ? exp_a[k] : exp_b[k-8];
            checks++;
            if (slice_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got %b exp 1", k, slice_valid); end
            checks++;
            if (slice_data !== e) begin errors++; $display("FAIL b2b_data beat %0d got %h exp %h", k, slice_data, e); end
            checks++;
            if (word_ready !== (k >= 8)) begin errors++; $display("FAIL b2b_word_ready beat %0d got %b exp %b", k, word_ready, k >= 8); end
            checks++;
            if (slice_first !== (k == 8)) begin errors++; $display("FAIL b2b_first beat %0d got %b exp %b", k, slice_first, k == 8); end
            @(negedge clk);
        end
        checks++;
        if (slice_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b exp 0", slice_valid); end
    endtask

    task automatic test_backpressure();
        word_data = WORD_A; word_valid = 1'b1; slice_ready = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (slice_data !== exp_a[2]) begin errors++; $display("FAIL bp_data_pre got %h exp %h", slice_data, exp_a[2]); end
        slice_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            checks++;
            if (slice_data !== exp_a[2]) begin errors++; $display("FAIL bp_hold_data cycle %0d got %h exp %h", h, slice_data, exp_a[2]); end
            checks++;
            if ({slice_valid, slice_first, slice_last} !== 3'b100) begin errors++; $display("FAIL bp_hold_flags cycle %0d got %b exp 100", h, {slice_valid, slice_first, slice_last}); end
        end
        slice_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (slice_data !== exp_a[3]) begin errors++; $display("FAIL bp_resume got %h exp %h", slice_data, exp_a[3]); end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_end_busy got %b exp 0", busy); end
    endtask

    task automatic test_flush();
        word_data = WORD_A; word_valid = 1'b1; slice_ready = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (slice_data !== exp_a[4]) begin errors++; $display("FAIL flush_pre_data got %h exp %h", slice_data, exp_a[4]); end
        flush = 1'b1; word_valid = 1'b1; word_data = WORD_B;
        #1;
        checks++;
        if (word_ready !== 1'b0) begin errors++; $display("FAIL flush_word_ready got %b exp 0", word_ready); end
        @(negedge clk);
        flush = 1'b0; word_valid = 1'b0;
        checks++;
        if (slice_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", slice_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
        checks++;
        if (slice_data !== 8'h00) begin errors++; $display("FAIL flush_data got %h exp 00", slice_data); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_no_accept got %b exp 0", busy); end
    endtask

    task automatic test_async_reset();
        word_data = WORD_A; word_valid = 1'b1; slice_ready = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (slice_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", slice_valid); end
        checks++;
        if (slice_data !== 8'h00) begin errors++; $display("FAIL areset_data got %h exp 00", slice_data); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
        checks++;
        if (word_ready !== 1'b1) begin errors++; $display("FAIL areset_word_ready got %b exp 1", word_ready); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (slice_valid !== 1'b0) begin errors++; $display("FAIL areset_after_valid got %b exp 0", slice_valid); end
    endtask

    initial begin
`ifdef SLICE_SER_MSB_FIRST_EN
        exp_a = '{8'h1D, 8'h2E, 8'h3A, 8'h4D, 8'h5B, 8'h6E, 8'h7E, 8'h8F};
        exp_b = '{8'hF7, 8'hE6, 8'hD5, 8'hC4, 8'hB3, 8'hA2, 8'h91, 8'h80};
`else
        exp_a = '{8'h8F, 8'h7E, 8'h6E, 8'h5B, 8'h4D, 8'h3A, 8'h2E, 8'h1D};
        exp_b = '{8'h80, 8'h91, 8'hA2, 8'hB3, 8'hC4, 8'hD5, 8'hE6, 8'hF7};
`endif
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
